// File: rtl/ad7606_pkg.sv
// ad7606_pkg: shared types, state encoding and frame geometry for the AD7606 frame packer.
package ad7606_pkg;
  typedef logic [7:0][15:0] adc_frame_t;
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
  localparam logic [7:0] FRAME_HDR0 = 8'hAA;
  localparam logic [7:0] FRAME_HDR1 = 8'h55;
  function automatic int frame_len(input int ch_num, input bit seq_en);
    return 3 + 2 * ch_num + (seq_en ? 1 : 0);
  endfunction
endpackage

// File: rtl/ad7606_frame_pack_frame_byte_mux.sv
// frame_byte_mux: maps a frame index to its header, SEQ or big-endian sample byte.
module frame_byte_mux
  import ad7606_pkg::*;
#(
  parameter logic [7:0] HDR0   = FRAME_HDR0,
  parameter logic [7:0] HDR1   = FRAME_HDR1,
  parameter bit         SEQ_EN = 1'b0
) (
  input  adc_frame_t  snap,
  input  logic [4:0]  idx,
  input  logic [7:0]  seq,
  output logic [7:0]  pbyte
);
  localparam logic [4:0] HDR_N = SEQ_EN ? 5'd3 : 5'd2;
  logic [3:0]  p;
  logic [15:0] s;
  always_comb begin
    p = 4'(idx - HDR_N);
    s = snap[p[3:1]];
    pbyte = idx == 5'd0 ? HDR0 :
            idx == 5'd1 ? HDR1 :
            (SEQ_EN && idx == 5'd2) ? seq :
            p[0] ? s[7:0] : s[15:8];
  end
endmodule

// File: rtl/ad7606_frame_pack.sv
// ad7606_frame_pack: latches ADC snapshots and streams them as checksummed byte frames; FRAME_SEQ_EN adds a sequence byte.
module ad7606_frame_pack
  import ad7606_pkg::*;
#(
  parameter int         CH_NUM = 8,
  parameter logic [7:0] HDR0   = FRAME_HDR0,
  parameter logic [7:0] HDR1   = FRAME_HDR1,
  parameter int         DECIM  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_done,
  input  adc_frame_t  adc_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        frame_busy,
  output logic [7:0]  overrun_cnt
);
`ifdef FRAME_SEQ_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif
  localparam int LEN = frame_len(CH_NUM, SEQ_EN);
  localparam logic [4:0] LAST = 5'(LEN - 2);
  state_t      state;
  adc_frame_t  snap;
  logic [4:0]  idx;
  logic [7:0]  dcnt, sum, seq, nx_byte;
`ifndef FRAME_SEQ_EN
  assign seq = 8'd0;
`endif
  frame_byte_mux #(.HDR0(HDR0), .HDR1(HDR1), .SEQ_EN(SEQ_EN)) u_mux (
    .snap(snap), .idx(idx + 5'd1), .seq(seq), .pbyte(nx_byte)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      snap <= '0;
      idx <= '0;
      dcnt <= '0;
      sum <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      frame_busy <= 1'b0;
      overrun_cnt <= '0;
`ifdef FRAME_SEQ_EN
      seq <= '0;
`endif
    end else begin
      if (adc_done && frame_busy && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      case (state)
        IDLE: if (adc_done) begin
          if (dcnt == 8'(DECIM - 1)) begin
            dcnt <= '0;
            snap <= adc_data;
            sum <= '0;
            idx <= '0;
            tx_data <= HDR0;
            tx_valid <= 1'b1;
            frame_busy <= 1'b1;
            state <= SEND;
          end else dcnt <= dcnt + 8'd1;
        end
        SEND: if (tx_ready) begin
          idx <= idx + 5'd1;
          if (idx >= 5'd2) sum <= sum + tx_data;
          if (idx == LAST) begin
            tx_data <= sum + tx_data;
            state <= CSUM;
          end else tx_data <= nx_byte;
        end
        CSUM: if (tx_ready) begin
          idx <= '0;
          tx_valid <= 1'b0;
          frame_busy <= 1'b0;
          state <= IDLE;
`ifdef FRAME_SEQ_EN
          seq <= seq + 8'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ad7606_frame_pack.sv
// tb_ad7606_frame_pack: directed checks of framing, handshake, overrun, decimation and reset for ad7606_frame_pack.
module tb_ad7606_frame_pack;
  import ad7606_pkg::*;
`ifdef FRAME_SEQ_EN
  localparam int LEN = 20;
`else
  localparam int LEN = 19;
`endif
  logic clk = 1'b0;
  logic rst, adc_done, tx_ready;
  adc_frame_t adc_data;
  logic [7:0] td1, oc1, td4, oc4;
  logic tv1, fb1, tv4, fb4;
  logic [7:0] exp_f [0:19];
  logic [7:0] seq_m, last_b;
  int total = 0, bad = 0, frames4;
  adc_frame_t base, ones, zero, other;

  ad7606_frame_pack dut (
    .clk(clk), .rst(rst), .adc_done(adc_done), .adc_data(adc_data), .tx_data(td1),
    .tx_valid(tv1), .tx_ready(tx_ready), .frame_busy(fb1), .overrun_cnt(oc1)
  );
  ad7606_frame_pack #(.DECIM(4)) dut4 (
    .clk(clk), .rst(rst), .adc_done(adc_done), .adc_data(adc_data), .tx_data(td4),
    .tx_valid(tv4), .tx_ready(tx_ready), .frame_busy(fb4), .overrun_cnt(oc4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic mk(input adc_frame_t d);
    int k;
    logic [7:0] cs;
    exp_f[0] = 8'hAA;
    exp_f[1] = 8'h55;
    k = 2;
`ifdef FRAME_SEQ_EN
    exp_f[2] = seq_m;
    k = 3;
`endif
    for (int i = 0; i < 8; i++) begin
      exp_f[k] = d[i][15:8];
      exp_f[k + 1] = d[i][7:0];
      k += 2;
    end
    cs = 8'd0;
    for (int i = 2; i < LEN - 1; i++) cs += exp_f[i];
    exp_f[LEN - 1] = cs;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", tv1, 0);
    chk("rst_busy", fb1, 0);
    chk("rst_data", td1, 0);
    chk("rst_ovr", oc1, 0);
    chk("rst_valid4", tv4, 0);
    chk("rst_busy4", fb4, 0);
    chk("rst_ovr4", oc4, 0);
    seq_m = 8'd0;
  endtask

  task automatic start(input adc_frame_t d);
    adc_data = d;
    adc_done = 1'b1;
    @(negedge clk);
    adc_done = 1'b0;
    chk("lat_valid", tv1, 1);
    chk("lat_hdr0", td1, 8'hAA);
    mk(d);
  endtask

  task automatic collect(input int pat, input int nmax);
    int n, cyc;
    logic held;
    logic [7:0] hold_d;
    n = 0; cyc = 0; held = 1'b0; hold_d = 8'd0;
    while (n < nmax && cyc < 200) begin
      if (held) begin
        chk("hold_valid", tv1, 1);
        chk("hold_data", td1, hold_d);
      end
      tx_ready = (pat == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      if (tv1 && tx_ready) begin
        chk($sformatf("byte%0d", n), td1, exp_f[n]);
        last_b = td1;
        n++;
        held = 1'b0;
      end else if (tv1) begin
        held = 1'b1;
        hold_d = td1;
      end
      @(negedge clk);
      cyc++;
    end
    chk("byte_count", n, nmax);
    if (nmax == LEN) begin
      chk("end_busy", fb1, 0);
      chk("end_valid", tv1, 0);
      seq_m++;
    end
  endtask

  initial begin
    rst = 1'b1; adc_done = 1'b0; tx_ready = 1'b0; adc_data = '0;
    seq_m = 8'd0; last_b = 8'd0;
    for (int i = 0; i < 8; i++) begin
      base[i] = {8'(2 * i + 1), 8'(2 * i + 2)};
      ones[i] = 16'hFFFF;
      zero[i] = 16'h0000;
      other[i] = 16'h5A5A + 16'(i);
    end
    @(negedge clk);
    do_reset();
    // basic frame, ready always high
    start(base);
    collect(0, LEN);
    chk("basic_csum", last_b, 8'h88);
    // backpressure 1,0,0,1
    start(base);
    collect(1, LEN);
    chk("bp_csum", last_b, 8'h88);
    // three overruns while stalled
    do_reset();
    tx_ready = 1'b0;
    start(base);
    for (int k = 0; k < 3; k++) begin
      adc_data = other;
      adc_done = 1'b1;
      @(negedge clk);
      adc_done = 1'b0;
      @(negedge clk);
    end
    chk("ovr3", oc1, 3);
    collect(0, LEN);
    repeat (5) @(negedge clk);
    chk("ovr_idle_valid", tv1, 0);
    chk("ovr_idle_busy", fb1, 0);
    // saturation
    tx_ready = 1'b0;
    start(base);
    adc_done = 1'b1;
    repeat (300) @(negedge clk);
    adc_done = 1'b0;
    chk("ovr_sat", oc1, 255);
    collect(0, LEN);
    // decimation by 4
    do_reset();
    tx_ready = 1'b1;
    frames4 = 0;
    for (int p = 1; p <= 8; p++) begin
      adc_data = base;
      adc_done = 1'b1;
      @(negedge clk);
      adc_done = 1'b0;
      chk($sformatf("decim_p%0d", p), tv4, (p % 4 == 0));
      if (tv4) begin
        chk("decim_hdr", td4, 8'hAA);
        frames4++;
      end
      repeat (30) @(negedge clk);
    end
    chk("decim_frames", frames4, 2);
    chk("decim_ovr", oc4, 0);
    // all-ones checksum
    do_reset();
    start(ones);
    collect(0, LEN);
    chk("ones_csum", last_b, 8'hF0);
    // reset after fifth transfer
    start(base);
    collect(0, 5);
    rst = 1'b1;
    tx_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_valid", tv1, 0);
    chk("mid_busy", fb1, 0);
    chk("mid_data", td1, 0);
    chk("mid_ovr", oc1, 0);
    seq_m = 8'd0;
    start(base);
    collect(0, LEN);
    // two zero frames
    do_reset();
    start(zero);
    collect(0, LEN);
    chk("zero1_csum", last_b, 8'h00);
    start(zero);
    collect(0, LEN);
`ifdef FRAME_SEQ_EN
    chk("zero2_csum", last_b, 8'h01);
`else
    chk("zero2_csum", last_b, 8'h00);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
